// File: rtl/ptn_seq_sel.sv
// Selects one of NUM_PTN column patterns by manual code or timed auto cycling, blanking on every change.
// col/idx/chg are registered: one cycle from input to output, no backpressure.
module ptn_seq_sel #(
    parameter int W       = 16,
    parameter int NUM_PTN = 6,
    parameter int BASE    = 4,
    parameter int DEF_IDX = NUM_PTN - 1,
    parameter int DWELL   = 1000,
    parameter int BLANK   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 mode,
    input  logic                       auto,
    input  logic                       dir,
    input  logic [NUM_PTN*W-1:0]       ptn_bus,
    output logic [W-1:0]               col,
    output logic [$clog2(NUM_PTN)-1:0] idx,
    output logic                       chg
);
    localparam int IW = $clog2(NUM_PTN);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_PTN - 1);
    localparam logic [IW-1:0] RST_IDX    = IW'(DEF_IDX);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);

    typedef enum logic [0:0] {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t        state, nxt_state;
    logic [DW-1:0] dwell_cnt, nxt_dwell;
    logic [BW-1:0] blank_cnt, nxt_blank;
    logic [IW-1:0] nxt_idx, tgt, req;
    logic [W-1:0]  nxt_col;
    logic          take, mode_ok;
    logic [W-1:0]  ptn [NUM_PTN];

    always_comb begin
        for (int k = 0; k < NUM_PTN; k++) begin
            ptn[k] = ptn_bus[k*W +: W];
        end
    end

    assign mode_ok = (int'(mode) >= BASE) && (int'(mode) <= BASE + NUM_PTN - 1);
    assign req     = IW'(int'(mode) - BASE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SHOW;
            idx       <= RST_IDX;
            col       <= '0;
            chg       <= 1'b0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= nxt_state;
            idx       <= nxt_idx;
            col       <= nxt_col;
            chg       <= take;
            dwell_cnt <= nxt_dwell;
            blank_cnt <= nxt_blank;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_dwell = '0;
        nxt_blank = blank_cnt;
        take      = 1'b0;
        tgt       = idx;

        // Dwell only advances on SHOW cycles in auto mode; it sits at 0 otherwise.
        if (auto) begin
            if (state == ST_SHOW) begin
                if (dwell_cnt == DWELL_LAST) begin
                    take = 1'b1;
                    if (dir) begin
                        tgt = (idx == '0) ? LAST_IDX : idx - IW'(1);
                    end else begin
                        tgt = (idx == LAST_IDX) ? '0 : idx + IW'(1);
                    end
                end else begin
                    nxt_dwell = dwell_cnt + DW'(1);
                end
            end
        end else if (mode_ok && (req != idx)) begin
            take = 1'b1;
            tgt  = req;
        end

        if (take) begin
            nxt_idx = tgt;
            if (BLANK > 0) begin
                nxt_state = ST_BLANK;
                nxt_blank = '0;
            end
        end else if (state == ST_BLANK) begin
            if (blank_cnt == BLANK_LAST) begin
                nxt_state = ST_SHOW;
                nxt_blank = '0;
            end else begin
                nxt_blank = blank_cnt + BW'(1);
            end
        end

        nxt_col = (nxt_state == ST_SHOW) ? ptn[nxt_idx] : '0;
    end
endmodule

// File: tb/tb_ptn_seq_sel.sv
// Bench for ptn_seq_sel: directed test-plan scenarios plus random traffic against a behavioural model.
module tb_ptn_seq_sel;
    localparam int W = 16, N = 6, BASE = 4, DWELL = 4, BLANK = 2, DEF = N - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     mode = 4'd9;
    logic           auto = 1'b0;
    logic           dir = 1'b0;
    logic [N*W-1:0] ptn_bus;
    logic [W-1:0]   col;
    logic [2:0]     idx;
    logic           chg;

    ptn_seq_sel #(.W(W), .NUM_PTN(N), .BASE(BASE), .DEF_IDX(DEF), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .mode(mode), .auto(auto), .dir(dir),
        .ptn_bus(ptn_bus), .col(col), .idx(idx), .chg(chg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: current index, remaining blank cycles, SHOW cycles seen in the current auto dwell.
    int         m_idx = DEF;
    int         blank_left = 0;
    int         shown = 0;
    logic [W-1:0] m_col = '0;
    logic       m_chg = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N*W-1:0] std_bus();
        logic [N*W-1:0] b;
        for (int k = 0; k < N; k++) b[k*W +: W] = 16'h1111 * 16'(k + 1);
        return b;
    endfunction

    task automatic step();
        logic           s_rst, s_auto, s_dir, change;
        logic [3:0]     s_mode;
        logic [N*W-1:0] s_bus;
        int             target;
        s_rst = rst; s_auto = auto; s_dir = dir; s_mode = mode; s_bus = ptn_bus;
        @(posedge clk);
        if (s_rst) begin
            m_idx = DEF; blank_left = 0; shown = 0; m_col = '0; m_chg = 1'b0;
        end else begin
            change = 1'b0;
            target = m_idx;
            if (!s_auto) begin
                shown = 0;
                if (int'(s_mode) >= BASE && int'(s_mode) < BASE + N && int'(s_mode) - BASE != m_idx) begin
                    change = 1'b1;
                    target = int'(s_mode) - BASE;
                end
            end else if (blank_left == 0) begin
                shown++;
                if (shown == DWELL) begin
                    change = 1'b1;
                    target = s_dir ? (m_idx + N - 1) % N : (m_idx + 1) % N;
                    shown = 0;
                end
            end else begin
                shown = 0;
            end
            if (change) begin
                m_idx = target;
                blank_left = BLANK;
                m_chg = 1'b1;
            end else begin
                m_chg = 1'b0;
                if (blank_left > 0) blank_left--;
            end
            m_col = (blank_left > 0) ? '0 : s_bus[m_idx*W +: W];
        end
        #1;
        cyc++;
        chk("col", col, m_col);
        chk("idx", idx, m_idx);
        chk("chg", chg, m_chg);
    endtask

    task automatic run_auto(input logic d, input int n_steps, input int e0, input int e1, input int e2);
        int prev = -1;
        int n = 0;
        int seq [3] = '{-1, -1, -1};
        auto = 1'b1; dir = d;
        for (int i = 0; i < n_steps; i++) begin
            step();
            if (chg) begin
                if (prev >= 0) chk("auto_gap", cyc - prev, DWELL + BLANK);
                prev = cyc;
                if (n < 3) seq[n] = idx;
                n++;
            end
        end
        chk("auto_seq0", seq[0], e0);
        chk("auto_seq1", seq[1], e1);
        if (e2 >= 0) chk("auto_seq2", seq[2], e2);
        auto = 1'b0;
    endtask

    initial begin
        ptn_bus = std_bus();
        // Reset with mode=9 held.
        step(); step();
        chk("rst_idx", idx, 5);
        chk("rst_col", col, 16'h0000);
        chk("rst_chg", chg, 0);
        rst = 1'b0;
        step();
        chk("first_col", col, 16'h6666);
        chk("first_chg", chg, 0);

        // Manual 9 -> 4.
        mode = 4'd4;
        step(); chk("m4_chg", chg, 1); chk("m4_idx", idx, 0); chk("m4_col1", col, 0);
        step(); chk("m4_col2", col, 0); chk("m4_chg2", chg, 0);
        step(); chk("m4_col3", col, 16'h1111);
        step();

        // Out-of-range codes hold index 0.
        mode = 4'd3;
        repeat (3) begin step(); chk("oor_col", col, 16'h1111); chk("oor_chg", chg, 0); end
        mode = 4'd15;
        repeat (3) begin step(); chk("oor_idx", idx, 0); chk("oor_chg", chg, 0); end

        // Auto up from index 4, then auto down from index 0.
        mode = 4'd8;
        repeat (5) step();
        run_auto(1'b0, 22, 5, 0, 1);
        mode = 4'd4;
        repeat (5) step();
        run_auto(1'b1, 16, 5, 4, -1);

        // Retarget during blank: 9 -> 5 -> 6.
        mode = 4'd9;
        repeat (5) step();
        mode = 4'd5;
        step(); chk("rt_chg1", chg, 1); chk("rt_idx1", idx, 1);
        mode = 4'd6;
        step(); chk("rt_chg2", chg, 1); chk("rt_idx2", idx, 2); chk("rt_col2", col, 0);
        step(); chk("rt_col3", col, 0); chk("rt_chg3", chg, 0);
        step(); chk("rt_col4", col, 16'h3333);

        // Reset during blank.
        mode = 4'd4;
        step();
        rst = 1'b1;
        step(); chk("rb_idx", idx, 5); chk("rb_col", col, 0); chk("rb_chg", chg, 0);
        rst = 1'b0; mode = 4'd9;
        repeat (3) step();

        // Reset mid-dwell, then dwell must restart from zero.
        auto = 1'b1; dir = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step(); chk("rd_idx", idx, 5); chk("rd_col", col, 0); chk("rd_chg", chg, 0);
        rst = 1'b0;
        repeat (12) step();
        auto = 1'b0;

        // Random traffic, including live pattern changes.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < N; k++) ptn_bus[k*W +: W] = 16'($urandom);
            end
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) == 0) auto = ~auto;
            if ($urandom_range(0, 9) == 0) dir = 1'($urandom);
            if ($urandom_range(0, 3) == 0) mode = 4'($urandom_range(0, 15));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
